// File: rtl/tug_of_war_match_if.sv
// Player-facing bundle for the tug-of-war match: two raw keys in; rope, scores and verdict out.
// Purely structural. No latency and no backpressure of its own.
interface tug_of_war_match_if #(
    parameter int NUM_POS = 9
);
    logic               key_l;
    logic               key_r;
    logic [NUM_POS-1:0] pos_leds;
    logic [3:0]         score_l;
    logic [3:0]         score_r;
    logic [6:0]         hex_l;
    logic [6:0]         hex_r;
    logic               match_over;
    logic [1:0]         winner;

    modport master (
        output key_l, key_r,
        input  pos_leds, score_l, score_r, hex_l, hex_r, match_over, winner
    );

    modport slave (
        input  key_l, key_r,
        output pos_leds, score_l, score_r, hex_l, hex_r, match_over, winner
    );
endinterface

// File: rtl/tug_of_war_match.sv
// Two-button tug-of-war: synchronised key presses move a one-hot rope LED, end hits score rounds.
// Latency: a raw key edge acts on state SYNC_STAGES+1 cycles later; display decode is combinational.
// No backpressure: presses arriving in HOLD/DONE (except a restart pair in DONE) are dropped.
module tug_of_war_match #(
    parameter int NUM_POS     = 9,
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    tug_of_war_match_if.slave   bus
);
    localparam int HCW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [NUM_POS-1:0] CENTRE = {{(NUM_POS-1){1'b0}}, 1'b1} << (NUM_POS / 2);
    localparam logic [3:0] WIN_SCORE = 4'(WIN_ROUNDS);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_POS-1:0] pos_q, pos_d;
    logic [3:0]         score_l_q, score_l_d;
    logic [3:0]         score_r_q, score_r_d;
    logic [1:0]         winner_q, winner_d;
    logic [HCW-1:0]     cnt_q, cnt_d;

    logic [SYNC_STAGES-1:0] sync_l_q, sync_r_q;
    logic                   edge_l_q, edge_r_q;
    logic                   press_l, press_r;

    // Synchronisers idle high (released) so reset never fabricates a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_l_q <= '1;
            sync_r_q <= '1;
            edge_l_q <= 1'b1;
            edge_r_q <= 1'b1;
        end else begin
            sync_l_q <= {sync_l_q[SYNC_STAGES-2:0], bus.key_l};
            sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], bus.key_r};
            edge_l_q <= sync_l_q[SYNC_STAGES-1];
            edge_r_q <= sync_r_q[SYNC_STAGES-1];
        end
    end

    assign press_l = edge_l_q & ~sync_l_q[SYNC_STAGES-1];
    assign press_r = edge_r_q & ~sync_r_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= PLAY;
            pos_q     <= CENTRE;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        case (state_q)
            PLAY: begin
                // A simultaneous pair falls through both branches and cancels, even at an end.
                if (press_l && !press_r) begin
                    if (pos_q[NUM_POS-1]) begin
                        if (score_l_q != WIN_SCORE) score_l_d = score_l_q + 4'd1;
                        winner_d = 2'b10;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        pos_d = pos_q << 1;
                    end
                end else if (press_r && !press_l) begin
                    if (pos_q[0]) begin
                        if (score_r_q != WIN_SCORE) score_r_d = score_r_q + 4'd1;
                        winner_d = 2'b01;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        pos_d = pos_q >> 1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if ((winner_q == 2'b10 && score_l_q == WIN_SCORE) ||
                        (winner_q == 2'b01 && score_r_q == WIN_SCORE)) begin
                        state_d = DONE;
                    end else begin
                        pos_d    = CENTRE;
                        winner_d = 2'b00;
                        state_d  = PLAY;
                    end
                end else begin
                    cnt_d = cnt_q + HCW'(1);
                end
            end
            DONE: begin
                if (press_l && press_r) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    pos_d     = CENTRE;
                    winner_d  = 2'b00;
                    cnt_d     = '0;
                    state_d   = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign bus.pos_leds   = pos_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.hex_l      = seg7(score_l_q);
    assign bus.hex_r      = seg7(score_r_q);
    assign bus.match_over = (state_q == DONE);
    assign bus.winner     = winner_q;
endmodule
